approx_adder_error_monitor: RTL and testbench



---
 rtl/approx_adder_error_monitor_if.sv | 26 ++
 rtl/approx_adder_error_monitor.sv | 129 ++++++++++++
 tb/tb_approx_adder_error_monitor.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/approx_adder_error_monitor_if.sv
// Bus between the error monitor and the approximate adder under test.
// The monitor side is the master; the adder/harness side is the slave.
interface approx_adder_error_monitor_if #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 3
);
    logic                  start;
    logic [IN_W-1:0]       dut_in;
    logic [OUT_W-1:0]      dut_out;
    logic                  busy;
    logic                  done;
    logic [OUT_W-1:0]      max_err;
    logic [IN_W+OUT_W-1:0] err_sum;
    logic [IN_W:0]         viol_cnt;
    logic                  pass;

    modport master (
        input  start, dut_out,
        output dut_in, busy, done, max_err, err_sum, viol_cnt, pass
    );

    modport slave (
        output start, dut_out,
        input  dut_in, busy, done, max_err, err_sum, viol_cnt, pass
    );
endinterface

// File: rtl/approx_adder_error_monitor.sv
// Sweeps every input vector through an approximate adder and accumulates
// max/sum of absolute error and threshold violations against exact a+b.
module approx_adder_error_monitor #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 3,
    parameter int ET    = 7
) (
    input logic clk,
    input logic rst_n,
    approx_adder_error_monitor_if.master bus
);
    localparam int HW = IN_W / 2;
    localparam int SW = IN_W + OUT_W;
    localparam int CW = IN_W + 1;
    localparam logic [31:0] ET_W = 32'(ET);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_e;

    state_e            state_q, state_d;
    logic [IN_W-1:0]   dut_in_q, dut_in_d;
    logic              drain_q, drain_d;
    logic              cap_valid_q, cap_valid_d;
    logic [HW-1:0]     cap_a_q, cap_a_d;
    logic [HW-1:0]     cap_b_q, cap_b_d;
    logic [OUT_W-1:0]  cap_y_q, cap_y_d;
    logic [OUT_W-1:0]  max_q, max_d;
    logic [SW-1:0]     sum_q, sum_d;
    logic [CW-1:0]     viol_q, viol_d;
    logic              pass_q, pass_d;

    logic [OUT_W:0]    exact;
    logic [OUT_W:0]    diff;
    logic [OUT_W:0]    mag;
    logic [OUT_W-1:0]  err;
    logic              viol;

    // Error is formed one bit wider than the output so the sign survives.
    always_comb begin
        exact = (OUT_W+1)'(cap_a_q) + (OUT_W+1)'(cap_b_q);
        diff  = {1'b0, cap_y_q} - exact;
        mag   = diff[OUT_W] ? -diff : diff;
        err   = mag[OUT_W-1:0];
        viol  = 32'(err) > ET_W;
    end

    always_comb begin
        state_d     = state_q;
        dut_in_d    = dut_in_q;
        drain_d     = drain_q;
        cap_valid_d = (state_q == SWEEP);
        cap_a_d     = dut_in_q[HW-1:0];
        cap_b_d     = dut_in_q[IN_W-1:HW];
        cap_y_d     = bus.dut_out;
        max_d       = max_q;
        sum_d       = sum_q;
        viol_d      = viol_q;
        pass_d      = pass_q;

        if (cap_valid_q) begin
            max_d  = (err > max_q) ? err : max_q;
            sum_d  = sum_q + SW'(err);
            viol_d = viol_q + CW'(viol);
            pass_d = 32'(max_d) <= ET_W;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = SWEEP;
                    dut_in_d = '0;
                    max_d    = '0;
                    sum_d    = '0;
                    viol_d   = '0;
                    pass_d   = 1'b1;
                end
            end
            SWEEP: begin
                if (dut_in_q == '1) begin
                    state_d = DRAIN;
                    drain_d = 1'b0;
                end else begin
                    dut_in_d = dut_in_q + IN_W'(1);
                end
            end
            DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dut_in_q    <= '0;
            drain_q     <= 1'b0;
            cap_valid_q <= 1'b0;
            cap_a_q     <= '0;
            cap_b_q     <= '0;
            cap_y_q     <= '0;
            max_q       <= '0;
            sum_q       <= '0;
            viol_q      <= '0;
            pass_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            dut_in_q    <= dut_in_d;
            drain_q     <= drain_d;
            cap_valid_q <= cap_valid_d;
            cap_a_q     <= cap_a_d;
            cap_b_q     <= cap_b_d;
            cap_y_q     <= cap_y_d;
            max_q       <= max_d;
            sum_q       <= sum_d;
            viol_q      <= viol_d;
            pass_q      <= pass_d;
        end
    end

    assign bus.dut_in   = dut_in_q;
    assign bus.busy     = (state_q == SWEEP) || (state_q == DRAIN);
    assign bus.done     = (state_q == DONE);
    assign bus.max_err  = max_q;
    assign bus.err_sum  = sum_q;
    assign bus.viol_cnt = viol_q;
    assign bus.pass     = pass_q;
endmodule

// File: tb/tb_approx_adder_error_monitor.sv
// Bench for the error monitor: three instances (ET 7, 5, 6) share start/reset
// and each drives a bench-side approximate adder selected by mode.
module tb_approx_adder_error_monitor;
    localparam int NV   = 16;
    localparam int DPOS = NV + 3;

    logic clk;
    logic rst_n;
    logic start;
    int   mode;
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    approx_adder_error_monitor_if #(.IN_W(4), .OUT_W(3)) if0 ();
    approx_adder_error_monitor_if #(.IN_W(4), .OUT_W(3)) if1 ();
    approx_adder_error_monitor_if #(.IN_W(4), .OUT_W(3)) if2 ();

    approx_adder_error_monitor #(.IN_W(4), .OUT_W(3), .ET(7)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.master));
    approx_adder_error_monitor #(.IN_W(4), .OUT_W(3), .ET(5)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.master));
    approx_adder_error_monitor #(.IN_W(4), .OUT_W(3), .ET(6)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(if2.master));

    function automatic logic [2:0] adder(input logic [3:0] v, input int m);
        int a;
        int b;
        a = int'(v[1:0]);
        b = int'(v[3:2]);
        if (m == 0) return 3'(a + b);
        if (m == 1) return 3'd0;
        return 3'd7;
    endfunction

    assign if0.start = start;
    assign if1.start = start;
    assign if2.start = start;
    assign if0.dut_out = adder(if0.dut_in, mode);
    assign if1.dut_out = adder(if1.dut_in, mode);
    assign if2.dut_out = adder(if2.dut_in, mode);

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference: error statistics over the first n vectors of the sweep.
    task automatic acc(input int m, input int n, input int et,
                       output int mx, output int sm, output int vc);
        mx = 0; sm = 0; vc = 0;
        for (int v = 0; v < n; v++) begin
            int a, b, y, e;
            a = v % 4;
            b = v / 4;
            y = (m == 0) ? a + b : ((m == 1) ? 0 : 7);
            e = y - (a + b);
            if (e < 0) e = -e;
            if (e > mx) mx = e;
            sm += e;
            if (e > et) vc++;
        end
    endtask

    int pos;
    int nvis;
    int exp_in;
    int smode;
    bit armed;

    task automatic cmp_inst(input int idx, input int et,
                            input logic [3:0] din, input logic bsy,
                            input logic dn, input logic [2:0] mx,
                            input logic [6:0] sm, input logic [4:0] vc,
                            input logic ps);
        int emx, esm, evc;
        acc(smode, nvis, et, emx, esm, evc);
        chk($sformatf("u%0d.dut_in", idx), 32'(din), 32'(exp_in));
        chk($sformatf("u%0d.busy", idx), 32'(bsy),
            32'(pos >= 1 && pos <= NV + 2));
        chk($sformatf("u%0d.done", idx), 32'(dn), 32'(pos == DPOS));
        chk($sformatf("u%0d.max_err", idx), 32'(mx), 32'(emx));
        chk($sformatf("u%0d.err_sum", idx), 32'(sm), 32'(esm));
        chk($sformatf("u%0d.viol_cnt", idx), 32'(vc), 32'(evc));
        chk($sformatf("u%0d.pass", idx), 32'(ps), 32'(emx <= et));
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            pos = 0; nvis = 0; exp_in = 0; armed = 1'b1;
        end else if (armed) begin
            if (pos == 0) begin
                if (start) begin
                    pos = 1; smode = mode;
                end
            end else if (pos == DPOS) begin
                pos = 0;
            end else begin
                pos++;
            end
            if (pos >= 1) begin
                exp_in = (pos - 1 > NV - 1) ? NV - 1 : pos - 1;
                nvis   = (pos < 3) ? 0 : ((pos - 2 > NV) ? NV : pos - 2);
            end
        end
        #1;
        if (armed) begin
            cmp_inst(0, 7, if0.dut_in, if0.busy, if0.done, if0.max_err,
                     if0.err_sum, if0.viol_cnt, if0.pass);
            cmp_inst(1, 5, if1.dut_in, if1.busy, if1.done, if1.max_err,
                     if1.err_sum, if1.viol_cnt, if1.pass);
            cmp_inst(2, 6, if2.dut_in, if2.busy, if2.done, if2.max_err,
                     if2.err_sum, if2.viol_cnt, if2.pass);
        end
    end

    task automatic pulse();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int lat;
        lat = 1;
        while (!if0.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk(nm, 32'(lat), 32'(DPOS));
    endtask

    task automatic lit(input string nm, input int mx, input int sm,
                       input int vc, input int ps);
        chk({nm, ".max_err"}, 32'(if0.max_err), 32'(mx));
        chk({nm, ".err_sum"}, 32'(if0.err_sum), 32'(sm));
        chk({nm, ".viol_cnt"}, 32'(if0.viol_cnt), 32'(vc));
        chk({nm, ".pass"}, 32'(if0.pass), 32'(ps));
    endtask

    initial begin
        int dn;
        checks = 0; errors = 0;
        rst_n = 1'b0; start = 1'b0; mode = 0;
        armed = 1'b0; pos = 0; nvis = 0; exp_in = 0; smode = 0;
        repeat (3) @(negedge clk);
        lit("reset", 0, 0, 0, 1);
        chk("reset.busy", 32'(if0.busy), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // exact adder: zero error everywhere
        mode = 0;
        pulse();
        chk("s1.first_in", 32'(if0.dut_in), 32'd0);
        wait_done("s1.done_lat");
        lit("s1", 0, 0, 0, 1);
        repeat (3) @(negedge clk);

        // output tied low
        mode = 1;
        pulse();
        wait_done("s2.done_lat");
        lit("s2", 6, 48, 0, 1);
        chk("s2.et5.viol", 32'(if1.viol_cnt), 32'd1);
        chk("s2.et5.pass", 32'(if1.pass), 32'd0);

        // idle hold, then a start must clear before the first sweep cycle
        repeat (10) @(negedge clk);
        lit("s6.hold", 6, 48, 0, 1);
        chk("s6.done", 32'(if0.done), 32'd0);
        mode = 2;
        pulse();
        chk("s6.clear.sum", 32'(if0.err_sum), 32'd0);
        chk("s6.clear.max", 32'(if0.max_err), 32'd0);
        chk("s6.et5.pass", 32'(if1.pass), 32'd1);
        wait_done("s3.done_lat");
        lit("s3", 7, 64, 0, 1);
        chk("s3.et6.viol", 32'(if2.viol_cnt), 32'd1);
        chk("s3.et6.pass", 32'(if2.pass), 32'd0);
        repeat (2) @(negedge clk);

        // start re-pulsed mid-sweep must be ignored
        mode = 0;
        pulse();
        repeat (4) @(negedge clk);
        pulse();
        repeat (6) @(negedge clk);
        pulse();
        dn = 0;
        repeat (10) begin
            if (if0.done) dn++;
            @(negedge clk);
        end
        chk("s4.done_cnt", 32'(dn), 32'd1);
        lit("s4", 0, 0, 0, 1);

        // reset mid-sweep aborts without done
        mode = 1;
        pulse();
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("s5.busy", 32'(if0.busy), 32'd0);
        chk("s5.done", 32'(if0.done), 32'd0);
        lit("s5.rst", 0, 0, 0, 1);
        repeat (3) @(negedge clk);
        pulse();
        wait_done("s5.done_lat");
        lit("s5", 6, 48, 0, 1);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
